// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/memory/write-back
// and drives the datapath strobes and mux selects as Moore outputs of the state register.
module multi_cycle_controller #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             illegal_q, illegal_d;
  logic             retire;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // IR still holds the load/store opcode here, so it picks the memory direction
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  assign retire = (state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) || (state_q == S_R_WB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) || (state_q == S_ADDI_WB);
  assign instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE:   alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state      = state_q;
  assign instr_cnt  = instr_cnt_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: a table of instructions with expected state
// sequences, per-state output expectations, and hand-written reset / wrap sequences.
module tb_multi_cycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_cnt;
  logic        illegal_op;

  // Narrow-counter instance used to exercise counter wrap-around
  logic        rst2;
  logic [5:0]  opcode2;
  logic        w_pw, w_pwc, w_ir, w_iod, w_mr, w_mw, w_m2r, w_rd, w_rw, w_asa;
  logic [1:0]  w_asb, w_aop, w_ps;
  logic [3:0]  w_state;
  logic [1:0]  w_cnt;
  logic        w_ill;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_cycle_controller #(.OP_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_cnt(instr_cnt), .illegal_op(illegal_op)
  );

  multi_cycle_controller #(.OP_W(6), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst2), .opcode(opcode2),
    .pc_write(w_pw), .pc_write_cond(w_pwc), .ir_write(w_ir),
    .i_or_d(w_iod), .mem_read(w_mr), .mem_write(w_mw),
    .mem_to_reg(w_m2r), .reg_dst(w_rd), .reg_write(w_rw),
    .alu_src_a(w_asa), .alu_src_b(w_asb), .alu_op(w_aop),
    .pc_source(w_ps), .state(w_state), .instr_cnt(w_cnt), .illegal_op(w_ill)
  );

  // Order: pw pwc ir iord mr mw m2r rd rw asa asb[2] aop[2] ps[2]
  logic [15:0] outs;
  assign outs = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  function automatic logic [15:0] exp_outs(input logic [3:0] s);
    logic pw, pwc, ir, iod, mr, mw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, ps;
    {pw, pwc, ir, iod, mr, mw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin mr = 1; ir = 1; pw = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, ir, iod, mr, mw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string          name;
    logic [5:0]     op;
    int             ncyc;
    logic [4:0][3:0] seq;   // seq[0] is the first state of the instruction
    logic           legal;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] exp_cnt;
  logic        exp_ill;

  initial begin
    vecs[0] = '{"lw",    6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1};
    vecs[1] = '{"sw",    6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b1};
    vecs[2] = '{"rtype", 6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b1};
    vecs[3] = '{"addi",  6'b001000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 1'b1};
    vecs[4] = '{"beq",   6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b1};
    vecs[5] = '{"j",     6'b000010, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 1'b1};
    vecs[6] = '{"illeg", 6'b111111, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b0};
    vecs[7] = '{"lw2",   6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1};

    rst = 1'b1; opcode = 6'b0; rst2 = 1'b1; opcode2 = 6'b000010;

    // Reset held for two cycles: everything idle, strobes and selects gated to zero
    step(); step();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_outs", 64'(outs), 64'd0);
    chk("rst_cnt", 64'(instr_cnt), 64'd0);
    chk("rst_ill", 64'(illegal_op), 64'd0);
    rst = 1'b0;
    #1;
    chk("fetch_after_rst", 64'(outs), 64'(exp_outs(4'd0)));

    exp_cnt = 32'd0;
    exp_ill = 1'b0;
    for (int v = 0; v < 8; v++) begin
      opcode = vecs[v].op;
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        chk($sformatf("%s_state_c%0d", vecs[v].name, c), 64'(state), 64'(vecs[v].seq[c]));
        chk($sformatf("%s_outs_c%0d", vecs[v].name, c), 64'(outs), 64'(exp_outs(vecs[v].seq[c])));
        step();
      end
      if (vecs[v].legal) exp_cnt = exp_cnt + 32'd1;
      else exp_ill = 1'b1;
      chk($sformatf("%s_back_to_fetch", vecs[v].name), 64'(state), 64'd0);
      chk($sformatf("%s_cnt", vecs[v].name), 64'(instr_cnt), 64'(exp_cnt));
      chk($sformatf("%s_ill", vecs[v].name), 64'(illegal_op), 64'(exp_ill));
      $display("instr %s op=%b cycles=%0d cnt=%0d ill=%0b", vecs[v].name, vecs[v].op,
               vecs[v].ncyc, instr_cnt, illegal_op);
    end

    // Reset arriving in MEM_READ aborts the lw without counting it
    opcode = 6'b100011;
    step(); step(); step();
    chk("mid_state3", 64'(state), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", 64'(outs), 64'd0);
    step();
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_cnt", 64'(instr_cnt), 64'd0);
    chk("mid_rst_ill", 64'(illegal_op), 64'd0);
    chk("mid_rst_outs2", 64'(outs), 64'd0);
    rst = 1'b0;
    step(); step(); step(); step(); step();
    chk("post_rst_lw_cnt", 64'(instr_cnt), 64'd1);
    $display("mid-instruction reset: cnt after following lw=%0d", instr_cnt);

    // Counter wrap on a 2-bit instance: four jumps take it 1,2,3,0
    rst2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(); step(); step();
      chk($sformatf("wrap_cnt_j%0d", k), 64'(w_cnt), 64'(k % 4));
      $display("wrap j%0d cnt=%0d", k, w_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
